aes_round_ctrl: RTL and testbench
=================================

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 Parameter NR, default 10, number of AES-128 rounds sequenced per block.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  plaintext/key pair offered.
REQ-005 in_ready  output  1  controller can accept a block; high only in IDLE.
REQ-006 plaintext  input  128  block to encrypt, sampled on acceptance.
REQ-007 key  input  128  cipher key, sampled on acceptance.
REQ-008 abort  input  1  synchronous cancel of the block in progress.
REQ-009 out_valid  output  1  ciphertext available.
REQ-010 out_ready  input  1  consumer takes ciphertext.
REQ-011 ciphertext  output  128  result register; meaningful only while out_valid=1.
REQ-012 busy  output  1  high in ROUND state.
REQ-013 round_idx  output  4  current round count (rc) driven to the datapath.

Function
REQ-014 FSM states SHALL be IDLE, ROUND and DONE.
REQ-015 IDLE: in_ready=1; on in_valid=1 -> state_reg <= plaintext ^ key (initial AddRoundKey), key_reg <= key, rc <= 1, go to ROUND.
REQ-016 ROUND: each cycle state_reg <= datapath round output, key_reg <= datapath next round key, rc <= rc+1.
REQ-017 Rounds 1..NR-1 SHALL use SubBytes, ShiftRows, MixColumns, AddRoundKey; round NR SHALL bypass MixColumns.
REQ-018 On the edge that processes rc=NR: ciphertext <= final-round output; go to DONE.
REQ-019 DONE: out_valid=1, ciphertext held stable; on out_ready=1 -> IDLE on that edge.
REQ-020 Latency: out_valid SHALL rise exactly NR rising edges after the accepting edge (10 for NR=10).
REQ-021 Throughput: one block per NR+2 cycles when out_ready is held at 1.
REQ-022 in_valid SHALL be ignored outside IDLE; no input is queued.
REQ-023 abort=1 in ROUND or DONE -> IDLE next edge, out_valid=0, ciphertext unchanged; abort has priority over out_ready and round progress.
REQ-024 abort=1 in IDLE together with in_valid=1: the block SHALL NOT be accepted.
REQ-025 rc SHALL never exceed NR; in IDLE and DONE round_idx SHALL read 0.
REQ-026 key_reg and state_reg SHALL NOT change in IDLE or DONE.

Reset
REQ-027 rst=1 SHALL force IDLE immediately, regardless of clock.
REQ-028 Reset values SHALL be: in_ready=1, out_valid=0, busy=0, round_idx=0, ciphertext=0, state_reg=0, key_reg=0.
REQ-029 Reset asserted mid-block SHALL discard the block; no out_valid pulse follows.

Structure
REQ-030 Shared package aes_pkg SHALL hold NR_AES128=10, the FSM state enum, and the 128-bit block typedef.
REQ-031 One sub-module aes_round_dp SHALL be instantiated: combinational (rc, data, key_in, final) -> (key_out, rndout), built from the team's key expansion, sub_byte, shift_rows and mix_columns blocks; final=1 bypasses mix_columns.
REQ-032 The controller SHALL contain all registers; aes_round_dp SHALL be purely combinational.

Verification
REQ-033 FIPS-197 App. B: pt 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c -> ciphertext 3925841d02dc09fbdc118597196a0b32, out_valid 10 edges after acceptance.
REQ-034 FIPS-197 C.1: pt 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f -> 69c4e0d86a7b0430d8cdb78070b4c55a; round_idx steps 1..10.
REQ-035 Backpressure: hold out_ready=0 for 20 cycles in DONE -> ciphertext and out_valid stable; in_valid pulses during this time are not accepted.
REQ-036 Abort at round 5 -> IDLE next cycle, no out_valid; a following B vector still yields 3925841d02dc09fbdc118597196a0b32.
REQ-037 Async rst pulse between clock edges at round 3 -> outputs take reset values before the next edge; no stale out_valid.
REQ-038 Back-to-back: in_valid and out_ready held at 1 with B then C.1 vectors -> two correct results, 12 cycles apart.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round count, FSM states, block type and the
// byte-level transforms used by the round datapath.
package aes_pkg;

  localparam int NR_AES128 = 10;

  typedef logic [127:0] aes_block_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } aes_state_e;

  // Forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    logic [10:0] idx;
    idx = {~b, 3'b000};
    return SBOX_TABLE[idx +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Round constant for the key schedule step that produces round key rc.
  function automatic logic [7:0] rcon(input logic [3:0] rc);
    case (rc)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Byte i of a block lives at bits [127-8i -: 8]; column c is bytes 4c..4c+3.
  function automatic aes_block_t sub_bytes(input aes_block_t d);
    aes_block_t o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sub_byte(d[8*i +: 8]);
    return o;
  endfunction

  function automatic aes_block_t shift_rows(input aes_block_t d);
    aes_block_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = d[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic aes_block_t mix_columns(input aes_block_t d);
    aes_block_t o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = d[127-32*c -: 8];
      a1 = d[119-32*c -: 8];
      a2 = d[111-32*c -: 8];
      a3 = d[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  // One step of the AES-128 key schedule: previous round key -> round key rc.
  function automatic aes_block_t key_expand(input aes_block_t k, input logic [3:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    w3 = k[31:0];
    t  = {sub_byte(w3[23:16]), sub_byte(w3[15:8]), sub_byte(w3[7:0]), sub_byte(w3[31:24])};
    t  = t ^ {rcon(rc), 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes_round_dp.sv
// Combinational AES-128 round: derives the next round key and applies one
// full round (final round skips MixColumns).
module aes_round_dp
  import aes_pkg::*;
(
  input  logic [3:0]   rc_i,
  input  aes_block_t   data_i,
  input  aes_block_t   key_i,
  input  logic         final_i,
  output aes_block_t   key_o,
  output aes_block_t   rnd_o
);

  aes_block_t sr;
  aes_block_t mc;

  // Round transform with the freshly expanded key added at the end.
  always_comb begin
    key_o = key_expand(key_i, rc_i);
    sr    = shift_rows(sub_bytes(data_i));
    mc    = final_i ? sr : mix_columns(sr);
    rnd_o = mc ^ key_o;
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption controller: accepts a block in IDLE, runs NR
// single-cycle rounds through aes_round_dp, then holds the result in DONE.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR = NR_AES128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  input  logic         abort,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy,
  output logic [3:0]   round_idx
);

  localparam logic [3:0] NR_RC = 4'(NR);

  aes_state_e fsm_q, fsm_d;
  logic [3:0] rc_q, rc_d;
  aes_block_t blk_q, blk_d;
  aes_block_t key_q, key_d;
  aes_block_t ct_q, ct_d;
  aes_block_t dp_key, dp_rnd;

  aes_round_dp u_dp (
    .rc_i    (rc_q),
    .data_i  (blk_q),
    .key_i   (key_q),
    .final_i (rc_q == NR_RC),
    .key_o   (dp_key),
    .rnd_o   (dp_rnd)
  );

  // Next-state logic; abort overrides both round progress and handshake.
  always_comb begin
    fsm_d = fsm_q;
    rc_d  = rc_q;
    blk_d = blk_q;
    key_d = key_q;
    ct_d  = ct_q;
    case (fsm_q)
      ST_IDLE: begin
        if (in_valid && !abort) begin
          blk_d = plaintext ^ key;
          key_d = key;
          rc_d  = 4'd1;
          fsm_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        if (abort) begin
          rc_d  = 4'd0;
          fsm_d = ST_IDLE;
        end else begin
          blk_d = dp_rnd;
          key_d = dp_key;
          if (rc_q == NR_RC) begin
            ct_d  = dp_rnd;
            rc_d  = 4'd0;
            fsm_d = ST_DONE;
          end else begin
            rc_d = rc_q + 4'd1;
          end
        end
      end
      ST_DONE: begin
        if (abort || out_ready) fsm_d = ST_IDLE;
      end
      default: begin
        rc_d  = 4'd0;
        fsm_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset drops any block in flight immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q <= ST_IDLE;
      rc_q  <= 4'd0;
      blk_q <= '0;
      key_q <= '0;
      ct_q  <= '0;
    end else begin
      fsm_q <= fsm_d;
      rc_q  <= rc_d;
      blk_q <= blk_d;
      key_q <= key_d;
      ct_q  <= ct_d;
    end
  end

  assign in_ready   = (fsm_q == ST_IDLE);
  assign busy       = (fsm_q == ST_ROUND);
  assign out_valid  = (fsm_q == ST_DONE);
  assign ciphertext = ct_q;
  assign round_idx  = (fsm_q == ST_ROUND) ? rc_q : 4'd0;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: algebraic AES-128 reference plus a cycle-level
// expectation of handshake/latency, checked every cycle, with directed and
// randomized stimulus.
module tb_aes_round_ctrl;

  localparam int NR = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] plaintext = '0;
  logic [127:0] key = '0;
  logic         abort = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] ciphertext;
  logic         busy;
  logic [3:0]   round_idx;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  aes_round_ctrl #(.NR(NR)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .plaintext(plaintext), .key(key), .abort(abort), .out_valid(out_valid),
    .out_ready(out_ready), .ciphertext(ciphertext), .busy(busy), .round_idx(round_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference AES from field arithmetic ----------------
  function automatic logic [7:0] gx(input logic [7:0] a);
    return (a << 1) ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = gx(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ref_sbox(input logic [7:0] b);
    logic [7:0] inv = 8'h01, base = b, s;
    int e = 254;
    for (int i = 0; i < 8; i++) begin
      if (e % 2 == 1) inv = gmul(inv, base);
      base = gmul(base, base);
      e = e / 2;
    end
    s = 8'h63;
    for (int k = 0; k < 5; k++) s = s ^ ((inv << k) | (inv >> (8 - k)));
    return s;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] kin);
    logic [7:0] s [16];
    logic [7:0] k [16];
    logic [7:0] t [16];
    logic [7:0] tmp [4];
    logic [7:0] rc = 8'h01;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      s[i] = pt[127-8*i -: 8] ^ kin[127-8*i -: 8];
      k[i] = kin[127-8*i -: 8];
    end
    for (int r = 1; r <= NR; r++) begin
      tmp[0] = ref_sbox(k[13]) ^ rc;
      tmp[1] = ref_sbox(k[14]);
      tmp[2] = ref_sbox(k[15]);
      tmp[3] = ref_sbox(k[12]);
      rc = gx(rc);
      for (int i = 0; i < 4; i++) k[i] = k[i] ^ tmp[i];
      for (int i = 4; i < 16; i++) k[i] = k[i] ^ k[i-4];
      for (int i = 0; i < 16; i++) s[i] = ref_sbox(s[i]);
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) t[rr+4*c] = s[rr+4*((c+rr)%4)];
      for (int c = 0; c < 4; c++) begin
        if (r < NR) begin
          s[4*c]   = gmul(t[4*c],2) ^ gmul(t[4*c+1],3) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(t[4*c+1],2) ^ gmul(t[4*c+2],3) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2],2) ^ gmul(t[4*c+3],3);
          s[4*c+3] = gmul(t[4*c],3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3],2);
        end else begin
          for (int rr = 0; rr < 4; rr++) s[4*c+rr] = t[4*c+rr];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- cycle-level expectation ----------------
  // m_phase: 0 waiting for a block, 1 computing (m_cnt rounds in), 2 result held.
  int           m_phase = 0;
  int           m_cnt = 0;
  logic [127:0] m_pend = '0;
  logic [127:0] m_ct = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_cnt   <= 0;
      m_ct    <= '0;
    end else if (m_phase == 0) begin
      if (in_valid && !abort) begin
        m_phase <= 1;
        m_cnt   <= 1;
        m_pend  <= aes_enc(plaintext, key);
      end
    end else if (m_phase == 1) begin
      if (abort) m_phase <= 0;
      else if (m_cnt == NR) begin
        m_phase <= 2;
        m_ct    <= m_pend;
      end else m_cnt <= m_cnt + 1;
    end else begin
      if (abort || out_ready) m_phase <= 0;
    end
  end

  // Every-cycle comparison of all outputs against the expectation.
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", 128'(in_ready), 128'(m_phase == 0));
      chk("busy", 128'(busy), 128'(m_phase == 1));
      chk("out_valid", 128'(out_valid), 128'(m_phase == 2));
      chk("round_idx", 128'(round_idx), (m_phase == 1) ? 128'(m_cnt) : 128'd0);
      if (m_phase == 2) chk("ciphertext", ciphertext, m_ct);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Offer one block, follow its rounds, return at the negedge out_valid is seen.
  task automatic start_and_wait(input logic [127:0] pt, input logic [127:0] k,
                                input logic [127:0] exp, input string nm);
    int edges = 0;
    chk({nm, "_ready_before"}, 128'(in_ready), 128'd1);
    in_valid = 1'b1; plaintext = pt; key = k; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && edges < 20) begin
      chk({nm, "_round_step"}, 128'(round_idx), 128'(edges + 1));
      @(negedge clk);
      edges++;
    end
    chk({nm, "_latency"}, 128'(edges), 128'(NR));
    chk({nm, "_result"}, ciphertext, exp);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic wait_round(input logic [3:0] target, input string nm);
    int n = 0;
    while (round_idx != target && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_reach_round"}, 128'(round_idx), 128'(target));
  endtask

  task automatic no_valid_for(input int n, input string nm);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk({nm, "_no_out_valid"}, 128'(seen), 128'd0);
  endtask

  initial begin
    logic [127:0] held;
    int t1, t2, got;
    logic [127:0] r1, r2;

    // Reference model pinned to the published vectors.
    chk("model_B", aes_enc(PT_B, KEY_B), CT_B);
    chk("model_C1", aes_enc(PT_C, KEY_C), CT_C);

    // Reset values while rst is held.
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_round_idx", 128'(round_idx), 128'd0);
    chk("rst_ciphertext", ciphertext, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // FIPS-197 App. B and C.1 vectors.
    start_and_wait(PT_B, KEY_B, CT_B, "vecB");
    consume();
    $display("vector B done ct=%h", ciphertext);
    start_and_wait(PT_C, KEY_C, CT_C, "vecC1");

    // Backpressure: result held 20 cycles, in_valid pulses ignored.
    held = ciphertext;
    for (int i = 0; i < 20; i++) begin
      in_valid = (i % 2 == 0);
      plaintext = {$urandom, $urandom, $urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      chk("bp_out_valid", 128'(out_valid), 128'd1);
      chk("bp_hold", ciphertext, held);
    end
    in_valid = 1'b0;
    consume();
    chk("bp_release", 128'(in_ready), 128'd1);
    $display("backpressure done ct=%h", held);

    // Abort at round 5, then a clean B vector.
    in_valid = 1'b1; plaintext = PT_C; key = KEY_C;
    @(negedge clk);
    in_valid = 1'b0;
    wait_round(4'd5, "abort");
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle", 128'(in_ready), 128'd1);
    no_valid_for(15, "abort");
    start_and_wait(PT_B, KEY_B, CT_B, "after_abort");
    consume();
    $display("abort test done");

    // abort together with in_valid in IDLE: not accepted.
    in_valid = 1'b1; abort = 1'b1; plaintext = PT_B; key = KEY_B;
    @(negedge clk);
    in_valid = 1'b0; abort = 1'b0;
    chk("abort_idle_reject", 128'(busy), 128'd0);

    // Asynchronous reset between edges at round 3.
    in_valid = 1'b1; plaintext = PT_B; key = KEY_B;
    @(negedge clk);
    in_valid = 1'b0;
    wait_round(4'd3, "arst");
    #2 rst = 1'b1;
    #1;
    chk("arst_in_ready", 128'(in_ready), 128'd1);
    chk("arst_busy", 128'(busy), 128'd0);
    chk("arst_out_valid", 128'(out_valid), 128'd0);
    chk("arst_round_idx", 128'(round_idx), 128'd0);
    chk("arst_ciphertext", ciphertext, 128'd0);
    #1 rst = 1'b0;
    no_valid_for(15, "arst");
    $display("async reset test done");

    // Back-to-back with in_valid and out_ready held high.
    got = 0; t1 = 0; t2 = 0; r1 = '0; r2 = '0;
    in_valid = 1'b1; out_ready = 1'b1; plaintext = PT_B; key = KEY_B;
    for (int i = 0; i < 40 && got < 2; i++) begin
      @(negedge clk);
      if (busy && got == 0) begin plaintext = PT_C; key = KEY_C; end
      if (out_valid) begin
        if (got == 0) begin t1 = cyc; r1 = ciphertext; end
        else begin t2 = cyc; r2 = ciphertext; in_valid = 1'b0; end
        got++;
      end
    end
    in_valid = 1'b0;
    chk("b2b_count", 128'(got), 128'd2);
    chk("b2b_first", r1, CT_B);
    chk("b2b_second", r2, CT_C);
    chk("b2b_spacing", 128'(t2 - t1), 128'(NR + 2));
    @(negedge clk);
    out_ready = 1'b0;
    idle(2);
    $display("back-to-back done spacing=%0d", t2 - t1);

    // Randomized traffic against the per-cycle expectation.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom % 2) == 0;
      plaintext = {$urandom, $urandom, $urandom, $urandom};
      key       = {$urandom, $urandom, $urandom, $urandom};
      out_ready = ($urandom % 3) != 0;
      abort     = ($urandom % 20) == 0;
      @(negedge clk);
    end
    in_valid = 1'b0; abort = 1'b0; out_ready = 1'b1;
    idle(15);
    out_ready = 1'b0;
    $display("random phase done");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
